fp_addmul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point unit. Ops: add, subtract, multiply.
- Next generation of the team's single-cycle single-precision add/mul FPU. Adds configurable exponent/fraction widths, valid/ready backpressure, special-value handling, RNE rounding via guard/round/sticky bits, and exception flags.
- Sits between the operand-issue logic and the result writeback, with one result per accepted operation in order.

---
 rtl/fp_addmul_pipe_if.sv | 31 +++
 rtl/fp_addmul_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_fp_addmul_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addmul_pipe_if.sv
// Operand-issue / result-writeback bundle for fp_addmul_pipe.
// The unit is the slave: it takes operand beats and offers results.
interface fp_addmul_pipe_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int INST_WIDTH = 2
);
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  // Beats move on valid & ready at the rising clock edge; an offered beat
  // (valid high) keeps its payload stable until it is taken.
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic [INST_WIDTH-1:0] i_inst;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [3:0]            o_flags;
  logic                  o_valid;
  logic                  i_ready;

  modport slave (
    input  i_data_a, i_data_b, i_inst, i_valid, i_ready,
    output o_ready, o_data, o_flags, o_valid
  );

  modport master (
    output i_data_a, i_data_b, i_inst, i_valid, i_ready,
    input  o_ready, o_data, o_flags, o_valid
  );
endinterface

// File: rtl/fp_addmul_pipe.sv
// 3-stage pipelined float add/sub/mul (unpack-align, combine-normalize, round-pack).
// Define FPU_RTZ_EN for round-toward-zero with overflow saturating to max finite.
module fp_addmul_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int INST_WIDTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fp_addmul_pipe_if.slave   fpu_if
);
  localparam int E   = EXP_WIDTH;
  localparam int F   = FRAC_WIDTH;
  localparam int M   = F + 1;
  localparam int W   = F + 4;
  localparam int XW  = E + 2;
  localparam int PW  = 2 * M;
  localparam int LZW = $clog2(W) + 1;
  localparam logic [E-1:0]            EXP_ONES = '1;
  localparam logic signed [XW-1:0]    BIAS     = XW'((1 << (E - 1)) - 1);
  localparam logic signed [XW-1:0]    EXP_MAX  = {2'b00, EXP_ONES};
  localparam logic signed [XW-1:0]    EXP_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0]   QNAN     = {1'b0, EXP_ONES, 1'b1, {(F-1){1'b0}}};
  localparam logic [INST_WIDTH-1:0]   OP_ADD   = INST_WIDTH'(0);
  localparam logic [INST_WIDTH-1:0]   OP_SUB   = INST_WIDTH'(1);
  localparam logic [INST_WIDTH-1:0]   OP_MUL   = INST_WIDTH'(2);

  logic adv;
  logic v1_q, v2_q, v3_q;

  // Stage 1: unpack, classify, align / multiply
  logic                  sa, sb, za, zb, ia, ib, na, nb, a_big, is_mul, is_rsv;
  logic [E-1:0]          ea, eb, el, es, d;
  logic [F-1:0]          fa, fb;
  logic [M-1:0]          ma, mb, ml, ms;
  logic [W-1:0]          al_s;
  logic [2*W-1:0]        sh;
  logic signed [XW-1:0]  exp_m;
  logic [PW-1:0]         prod;
  logic                  spec1_d;
  logic [DATA_WIDTH-1:0] sdata1_d;
  logic [3:0]            sflags1_d;

  always_comb begin
    sa     = fpu_if.i_data_a[DATA_WIDTH-1];
    ea     = fpu_if.i_data_a[DATA_WIDTH-2:F];
    fa     = fpu_if.i_data_a[F-1:0];
    eb     = fpu_if.i_data_b[DATA_WIDTH-2:F];
    fb     = fpu_if.i_data_b[F-1:0];
    sb     = fpu_if.i_data_b[DATA_WIDTH-1] ^ (fpu_if.i_inst == OP_SUB);
    is_mul = (fpu_if.i_inst == OP_MUL);
    is_rsv = (fpu_if.i_inst != OP_ADD) && (fpu_if.i_inst != OP_SUB) && !is_mul;
    za     = (ea == '0);
    zb     = (eb == '0);
    ia     = (ea == EXP_ONES) && (fa == '0);
    ib     = (eb == EXP_ONES) && (fb == '0);
    na     = (ea == EXP_ONES) && (fa != '0);
    nb     = (eb == EXP_ONES) && (fb != '0);
    // Subnormals flush to zero by dropping their fraction along with the hidden bit
    ma     = za ? '0 : {1'b1, fa};
    mb     = zb ? '0 : {1'b1, fb};
    a_big  = ({ea, ma} >= {eb, mb});
    el     = a_big ? ea : eb;
    es     = a_big ? eb : ea;
    ml     = a_big ? ma : mb;
    ms     = a_big ? mb : ma;
    d      = el - es;
    sh     = {ms, 3'b000, {W{1'b0}}} >> d;
    if (32'(d) > 32'(W - 1)) al_s = {{(W-1){1'b0}}, |ms};
    else                     al_s = sh[2*W-1:W] | {{(W-1){1'b0}}, |sh[W-1:0]};
    exp_m  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    prod   = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};

    spec1_d   = 1'b0;
    sdata1_d  = '0;
    sflags1_d = 4'b0000;
    if (is_rsv) begin
      spec1_d   = 1'b1;
      sflags1_d = 4'b1000;
    end else if (na || nb) begin
      spec1_d  = 1'b1;
      sdata1_d = QNAN;
    end else if (is_mul) begin
      if ((ia || ib) && (za || zb)) begin
        spec1_d   = 1'b1;
        sdata1_d  = QNAN;
        sflags1_d = 4'b1000;
      end else if (ia || ib) begin
        spec1_d  = 1'b1;
        sdata1_d = {sa ^ sb, EXP_ONES, {F{1'b0}}};
      end
    end else if (ia && ib && (sa != sb)) begin
      spec1_d   = 1'b1;
      sdata1_d  = QNAN;
      sflags1_d = 4'b1000;
    end else if (ia || ib) begin
      spec1_d  = 1'b1;
      sdata1_d = {ia ? sa : sb, EXP_ONES, {F{1'b0}}};
    end
  end

  logic                  mul1_q, spec1_q, sign1_q, esub1_q, zero1_q;
  logic [DATA_WIDTH-1:0] sdata1_q;
  logic [3:0]            sflags1_q;
  logic signed [XW-1:0]  exp1_q;
  logic [W-1:0]          sigl1_q, sigs1_q;
  logic [PW-1:0]         prod1_q;

  // Stage 2: effective add/subtract with normalisation, or product normalisation
  logic [W:0]            sum;
  logic [W-1:0]          diff;
  logic [PW-1:0]         pn;
  logic [LZW-1:0]        lz;
  logic                  found;
  logic [W-1:0]          mant2_d;
  logic signed [XW-1:0]  exp2_d;
  logic                  zero2_d, sign2_d;

  always_comb begin
    sum     = {1'b0, sigl1_q} + {1'b0, sigs1_q};
    diff    = sigl1_q - sigs1_q;
    pn      = prod1_q[PW-1] ? prod1_q : (prod1_q << 1);
    lz      = '0;
    found   = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else         lz    = lz + 1'b1;
      end
    end
    mant2_d = '0;
    exp2_d  = exp1_q;
    zero2_d = 1'b0;
    sign2_d = sign1_q;
    if (mul1_q) begin
      exp2_d  = exp1_q + $signed({{(XW-1){1'b0}}, prod1_q[PW-1]});
      mant2_d = {pn[PW-1:F-1], |pn[F-2:0]};
      zero2_d = zero1_q;
    end else if (!esub1_q) begin
      zero2_d = (sum == '0);
      if (sum[W]) begin
        mant2_d = {sum[W:2], |sum[1:0]};
        exp2_d  = exp1_q + $signed({{(XW-1){1'b0}}, 1'b1});
      end else begin
        mant2_d = sum[W-1:0];
      end
    end else begin
      zero2_d = (diff == '0);
      mant2_d = diff << lz;
      exp2_d  = exp1_q - $signed({{(XW-LZW){1'b0}}, lz});
      if (diff == '0) sign2_d = 1'b0;
    end
  end

  logic                  spec2_q, sign2_q, zero2_q;
  logic [DATA_WIDTH-1:0] sdata2_q;
  logic [3:0]            sflags2_q;
  logic signed [XW-1:0]  exp2_q;
  logic [W-1:0]          mant2_q;

  // Stage 3: round on {LSB, G, R|S}, then range-check and pack
  logic                  inc, inexact;
  logic [M:0]            rounded;
  logic signed [XW-1:0]  exp_r;
  logic [F-1:0]          frac_r;
  logic [DATA_WIDTH-1:0] data3_d;
  logic [3:0]            flags3_d;

  always_comb begin
    inexact = |mant2_q[2:0];
`ifdef FPU_RTZ_EN
    inc     = 1'b0;
`else
    inc     = mant2_q[2] & (mant2_q[1] | mant2_q[0] | mant2_q[3]);
`endif
    rounded = {1'b0, mant2_q[W-1:3]} + {{M{1'b0}}, inc};
    exp_r   = exp2_q + $signed({{(XW-1){1'b0}}, rounded[M]});
    frac_r  = rounded[M] ? rounded[F:1] : rounded[F-1:0];
    data3_d  = {sign2_q, exp_r[E-1:0], frac_r};
    flags3_d = {3'b000, inexact};
    if (spec2_q) begin
      data3_d  = sdata2_q;
      flags3_d = sflags2_q;
    end else if (zero2_q) begin
      data3_d  = {sign2_q, {(DATA_WIDTH-1){1'b0}}};
      flags3_d = 4'b0000;
    end else if (exp_r >= EXP_MAX) begin
`ifdef FPU_RTZ_EN
      data3_d  = {sign2_q, EXP_ONES - 1'b1, {F{1'b1}}};
`else
      data3_d  = {sign2_q, EXP_ONES, {F{1'b0}}};
`endif
      flags3_d = 4'b0101;
    end else if (exp_r <= EXP_ZERO) begin
      data3_d  = {sign2_q, {(DATA_WIDTH-1){1'b0}}};
      flags3_d = 4'b0011;
    end
  end

  logic [DATA_WIDTH-1:0] data3_q;
  logic [3:0]            flags3_q;

  // The whole pipe moves together whenever the output slot is free or draining
  assign adv            = ~v3_q | fpu_if.i_ready;
  assign fpu_if.o_ready = adv;
  assign fpu_if.o_valid = v3_q;
  assign fpu_if.o_data  = data3_q;
  assign fpu_if.o_flags = flags3_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      mul1_q <= 1'b0; spec1_q <= 1'b0; sign1_q <= 1'b0; esub1_q <= 1'b0; zero1_q <= 1'b0;
      sdata1_q <= '0; sflags1_q <= '0; exp1_q <= '0; sigl1_q <= '0; sigs1_q <= '0; prod1_q <= '0;
      spec2_q <= 1'b0; sign2_q <= 1'b0; zero2_q <= 1'b0;
      sdata2_q <= '0; sflags2_q <= '0; exp2_q <= '0; mant2_q <= '0;
      data3_q <= '0; flags3_q <= '0;
    end else if (adv) begin
      v1_q <= fpu_if.i_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (fpu_if.i_valid) begin
        mul1_q    <= is_mul;
        spec1_q   <= spec1_d;
        sdata1_q  <= sdata1_d;
        sflags1_q <= sflags1_d;
        sign1_q   <= is_mul ? (sa ^ sb) : (a_big ? sa : sb);
        esub1_q   <= sa ^ sb;
        zero1_q   <= za | zb;
        exp1_q    <= is_mul ? exp_m : $signed({2'b00, el});
        sigl1_q   <= {ml, 3'b000};
        sigs1_q   <= al_s;
        prod1_q   <= prod;
      end
      if (v1_q) begin
        spec2_q   <= spec1_q;
        sdata2_q  <= sdata1_q;
        sflags2_q <= sflags1_q;
        sign2_q   <= sign2_d;
        zero2_q   <= zero2_d;
        exp2_q    <= exp2_d;
        mant2_q   <= mant2_d;
      end
      if (v2_q) begin
        data3_q  <= data3_d;
        flags3_q <= flags3_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_addmul_pipe.sv
// Directed bench for fp_addmul_pipe: vector table through a result scoreboard,
// plus latency, backpressure and mid-stream reset sequences.
module tb_fp_addmul_pipe;
  localparam int EW = 8;
  localparam int FW = 23;
  localparam int IW = 2;
  localparam int NV = 21;

`ifdef FPU_RTZ_EN
  localparam logic [31:0] TIE_D   = 32'h3F800001;
  localparam logic [31:0] OVF_D   = 32'h7F7FFFFF;
  localparam logic [31:0] CARRY_D = 32'h3FFFFFFF;
`else
  localparam logic [31:0] TIE_D   = 32'h3F800002;
  localparam logic [31:0] OVF_D   = 32'h7F800000;
  localparam logic [31:0] CARRY_D = 32'h40000000;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  inst;
    logic [31:0] d;
    logic [3:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vec_t vecs [NV];
  int   checks = 0;
  int   passes = 0;
  logic [35:0] exp_q [$];
  string       name_q [$];

  fp_addmul_pipe_if #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .INST_WIDTH(IW)) bus ();

  fp_addmul_pipe #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .INST_WIDTH(IW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fpu_if  (bus)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // scoreboard: every consumed result must match the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got data=%h flags=%b, expected no result",
                   bus.o_data, bus.o_flags);
        end else begin
          logic [35:0] e;
          string       n;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check_eq(n, {bus.o_data, bus.o_flags}, e);
        end
      end
    end
  end

  // driver: call at a falling edge; returns at the falling edge after acceptance
  task automatic send(input vec_t v, input string name);
    logic acc;
    acc = 1'b0;
    bus.i_data_a = v.a;
    bus.i_data_b = v.b;
    bus.i_inst   = v.inst;
    bus.i_valid  = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      #1;
      acc = bus.o_ready;
      if (acc) begin
        exp_q.push_back({v.d, v.f});
        name_q.push_back(name);
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL %s_accept: o_ready stayed 0, required 1 within 50 cycles", name);
    end
  endtask

  task automatic measure_latency(input string name);
    int   lat;
    logic seen;
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (bus.o_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check_eq(name, 36'(lat), 36'd3);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq(name, 36'(exp_q.size()), 36'd0);
  endtask

  initial begin
    int acc_n;
    int idx;
    int cyc;

    vecs[0]  = '{32'h3FC00000, 32'h40100000, 2'd0, 32'h40700000, 4'b0000};
    vecs[1]  = '{32'h3FC00000, 32'h40000000, 2'd2, 32'h40400000, 4'b0000};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 2'd1, 32'h00000000, 4'b0000};
    vecs[3]  = '{32'h3F800001, 32'h33800000, 2'd0, TIE_D,        4'b0001};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 2'd2, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{32'h7F7FFFFF, 32'h40000000, 2'd2, OVF_D,        4'b0101};
    vecs[6]  = '{32'h40100000, 32'h3FC00000, 2'd1, 32'h3F400000, 4'b0000};
    vecs[7]  = '{32'h3FC00000, 32'h40100000, 2'd1, 32'hBF400000, 4'b0000};
    vecs[8]  = '{32'hBFC00000, 32'h40000000, 2'd2, 32'hC0400000, 4'b0000};
    vecs[9]  = '{32'h80000000, 32'h3F800000, 2'd2, 32'h80000000, 4'b0000};
    vecs[10] = '{32'h00800000, 32'h3F000000, 2'd2, 32'h00000000, 4'b0011};
    vecs[11] = '{32'h00000001, 32'h3F800000, 2'd0, 32'h3F800000, 4'b0000};
    vecs[12] = '{32'h3F800000, 32'h33000000, 2'd0, 32'h3F800000, 4'b0001};
    vecs[13] = '{32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b0000};
    vecs[14] = '{32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000, 4'b1000};
    vecs[15] = '{32'h7F800000, 32'h3F800000, 2'd0, 32'h7F800000, 4'b0000};
    vecs[16] = '{32'h3F800000, 32'h3F800000, 2'd3, 32'h00000000, 4'b1000};
    vecs[17] = '{32'h3FFFFFFF, 32'h33800000, 2'd0, CARRY_D,      4'b0001};
    vecs[18] = '{32'h3FC00000, 32'h3FC00000, 2'd2, 32'h40100000, 4'b0000};
    vecs[19] = '{32'h3FC00000, 32'h3FC00000, 2'd0, 32'h40400000, 4'b0000};
    vecs[20] = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800002, 4'b0001};

    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_inst   = '0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_o_valid", 36'(bus.o_valid), 36'd0);
    check_eq("rst_o_data",  36'(bus.o_data),  36'd0);
    check_eq("rst_o_flags", 36'(bus.o_flags), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("ready_after_rst", 36'(bus.o_ready), 36'd1);
    @(negedge clk);

    // single op latency
    send(vecs[0], "lat_add");
    measure_latency("latency");
    wait_drain("drain_lat");

    // vector table, back to back
    @(negedge clk);
    for (int i = 0; i < NV; i++) send(vecs[i], $sformatf("vec%0d", i));
    wait_drain("drain_table");

    // backpressure: five offered beats against a stalled output
    @(negedge clk);
    bus.i_ready = 1'b0;
    idx   = 0;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      bus.i_data_a = vecs[idx].a;
      bus.i_data_b = vecs[idx].b;
      bus.i_inst   = vecs[idx].inst;
      bus.i_valid  = 1'b1;
      #1;
      if (bus.o_ready) begin
        exp_q.push_back({vecs[idx].d, vecs[idx].f});
        name_q.push_back($sformatf("bp%0d", idx));
        idx++;
        acc_n++;
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    #1;
    check_eq("bp_accepted",  36'(acc_n), 36'd3);
    check_eq("bp_ready_low", 36'(bus.o_ready), 36'd0);
    check_eq("bp_hold0", {bus.o_data, bus.o_flags}, {vecs[0].d, vecs[0].f});
    repeat (2) @(negedge clk);
    #1;
    check_eq("bp_hold1", {bus.o_data, bus.o_flags}, {vecs[0].d, vecs[0].f});
    @(negedge clk);
    bus.i_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("bp_drain_cycles", 36'(cyc), 36'd3);
    #1;
    check_eq("bp_empty", 36'(bus.o_valid), 36'd0);

    // reset with three ops in flight
    @(negedge clk);
    bus.i_ready = 1'b0;
    send(vecs[6], "rst_a");
    send(vecs[7], "rst_b");
    send(vecs[8], "rst_c");
    #1;
    check_eq("rst_inflight_valid", 36'(bus.o_valid), 36'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 36'(bus.o_valid), 36'd0);
    check_eq("rst_async_data",  36'(bus.o_data),  36'd0);
    exp_q.delete();
    name_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    send(vecs[1], "post_rst");
    measure_latency("post_rst_latency");
    wait_drain("drain_post_rst");
    repeat (8) @(negedge clk);
    #1;
    check_eq("post_rst_idle", 36'(bus.o_valid), 36'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
